// File: rtl/elixirchip_es1_spu_op_logic.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_logic
//
// Multi-function bitwise logic unit for the ES1 SPU op library. One of eight
// two-operand bitwise functions is chosen per beat by s_op. Operand b is
// either s_data1 or the internal accumulator (s_acc=1). The accumulator is
// loaded with every valid result, which allows running reductions across a
// stream. A clear beat emits CLEAR_DATA and reloads the accumulator with
// ACC_INIT. The result passes through a LATENCY-deep pipeline gated by cke.
//
// Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a&~b),
//          7 ORN (a|~b)
//
// Optional feature macro: ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
//   When defined, adds m_zero: 1 when the result is all-zero. It is computed
//   in stage 1 and pipelined alongside m_data.
//
// Ports:
//   clk      clock
//   reset    synchronous reset, active-high
//   cke      clock enable; every register holds when 0
//   s_data0  operand a
//   s_data1  operand b (ignored when s_acc=1)
//   s_op     opcode
//   s_acc    1: operand b is the accumulator
//   s_clear  clear beat (overrides s_op and s_acc)
//   s_valid  beat valid
//   m_data   result
//   m_valid  result valid
//   m_zero   result is all-zero (only with the zero-flag macro)
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_op_logic #(
  parameter int    LATENCY         = 1,
  parameter int    DATA_BITS       = 8,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA      = '0,
  parameter data_t RESET_DATA      = '0,
  parameter data_t ACC_INIT        = '0,
  parameter bit    IMMEDIATE_DATA1 = 1'b0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cke,
  input  data_t      s_data0,
  input  data_t      s_data1,
  input  logic [2:0] s_op,
  input  logic       s_acc,
  input  logic       s_clear,
  input  logic       s_valid,
  output data_t      m_data,
  output logic       m_valid
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
  ,
  output logic       m_zero
`endif
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_logic: LATENCY must be >= 1");
  end

  // Implementation hints only; this portable RTL behaves identically for
  // every value, so the block below is intentionally empty.
  localparam bit HINTS_SET = IMMEDIATE_DATA1 || (DEVICE != "RTL") ||
                             (SIMULATION == "true") || (DEBUG == "true");
  if (HINTS_SET) begin : g_hints
  end

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_ORN  = 3'd7
  } op_e;

  data_t acc_q;
  data_t data_q  [LATENCY];
  logic  valid_q [LATENCY];

  data_t operand_b;
  data_t result;

  // Stage-1 function evaluation.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    operand_b = s_acc ? acc_q : s_data1;
    result    = '0;
    case (op_e'(s_op))
      OP_AND:  result = s_data0 & operand_b;
      OP_OR:   result = s_data0 | operand_b;
      OP_XOR:  result = s_data0 ^ operand_b;
      OP_NAND: result = ~(s_data0 & operand_b);
      OP_NOR:  result = ~(s_data0 | operand_b);
      OP_XNOR: result = ~(s_data0 ^ operand_b);
      OP_ANDN: result = s_data0 & ~operand_b;
      OP_ORN:  result = s_data0 | ~operand_b;
      default: result = '0;
    endcase
  end

  // NOTE: all state is written with non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the shift order is irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= RESET_DATA;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i]  <= RESET_DATA;
        valid_q[i] <= 1'b0;
      end
    end else if (cke) begin
      // Stage 1: data and accumulator only move on a valid beat, so the
      // accumulator is always the most recent valid result (zero bubble).
      valid_q[0] <= s_valid;
      if (s_valid) begin
        if (s_clear) begin
          data_q[0] <= CLEAR_DATA;
          acc_q     <= ACC_INIT;
        end else begin
          data_q[0] <= result;
          acc_q     <= result;
        end
      end
      // Stages 2..LATENCY: plain shift, data moves even behind invalid slots.
      for (int i = 1; i < LATENCY; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign m_data  = data_q[LATENCY-1];
  assign m_valid = valid_q[LATENCY-1];

`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
  logic zero_q [LATENCY];

  // Zero flag follows the same hold/shift rules as the data stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        zero_q[i] <= 1'b0;
      end
    end else if (cke) begin
      if (s_valid) begin
        zero_q[0] <= s_clear ? (CLEAR_DATA == '0) : (result == '0);
      end
      for (int i = 1; i < LATENCY; i++) begin
        zero_q[i] <= zero_q[i-1];
      end
    end
  end

  assign m_zero = zero_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// ---------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_logic
//
// Scoreboard bench. The driver applies directed and random beats on the
// falling edge and, for every beat the design will accept, pushes the
// expected result (from an opcode-table reference and a software
// accumulator) together with the cke-edge count at which it must appear.
// The monitor samples just after each rising edge and pops/compares whenever
// m_valid is high, checks frozen outputs while cke is low, and checks the
// reset values after any reset edge.
// ---------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_logic;

  localparam int         LATENCY    = 3;
  localparam int         DATA_BITS  = 8;
  localparam logic [7:0] CLEAR_DATA = 8'h3C;
  localparam logic [7:0] RESET_DATA = 8'h5A;
  localparam logic [7:0] ACC_INIT   = 8'h06;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cke = 1'b1;
  logic [7:0] s_data0 = '0;
  logic [7:0] s_data1 = '0;
  logic [2:0] s_op = '0;
  logic       s_acc = 1'b0;
  logic       s_clear = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
  logic       m_zero;
`endif

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         drv_edges = 0;
  int         mon_edges = 0;
  logic [7:0] model_acc = RESET_DATA;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_logic #(
    .LATENCY   (LATENCY),
    .DATA_BITS (DATA_BITS),
    .CLEAR_DATA(CLEAR_DATA),
    .RESET_DATA(RESET_DATA),
    .ACC_INIT  (ACC_INIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cke    (cke),
    .s_data0(s_data0),
    .s_data1(s_data1),
    .s_op   (s_op),
    .s_acc  (s_acc),
    .s_clear(s_clear),
    .s_valid(s_valid),
    .m_data (m_data),
    .m_valid(m_valid)
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
    ,
    .m_zero (m_zero)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Opcode table from the operation definitions.
  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a | ~b;
    endcase
  endfunction

  // Apply one cycle of inputs and predict what the coming rising edge does.
  task automatic drive(input logic rst, input logic ck, input logic vld, input logic clr,
                       input logic acc, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    reset = rst; cke = ck; s_valid = vld; s_clear = clr;
    s_acc = acc; s_op = op; s_data0 = a; s_data1 = b;
    if (rst) begin
      sb.delete();
      model_acc = RESET_DATA;
    end else if (ck) begin
      drv_edges++;
      if (vld) begin
        if (clr) begin
          e.data    = CLEAR_DATA;
          model_acc = ACC_INIT;
        end else begin
          e.data    = ref_op(op, a, acc ? model_acc : b);
          model_acc = e.data;
        end
        e.zero = (e.data == 8'h00);
        e.due  = drv_edges + LATENCY - 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic ck);
    for (int i = 0; i < n; i++) drive(1'b0, ck, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    logic       rst_s, cke_s;
    logic [7:0] prev_data;
    logic       prev_valid;
    exp_t       e;
    prev_data  = RESET_DATA;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      rst_s = reset;
      cke_s = cke;
      if (!rst_s && cke_s) mon_edges++;
      #1;
      if (rst_s) begin
        check("reset m_valid", {31'd0, m_valid}, 32'd0);
        check("reset m_data", {24'd0, m_data}, {24'd0, RESET_DATA});
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
        check("reset m_zero", {31'd0, m_zero}, 32'd0);
`endif
      end else if (!cke_s) begin
        check("hold m_data", {24'd0, m_data}, {24'd0, prev_data});
        check("hold m_valid", {31'd0, m_valid}, {31'd0, prev_valid});
      end else if (m_valid) begin
        if (sb.size() == 0) begin
          check("unexpected m_valid", {31'd0, m_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("m_data", {24'd0, m_data}, {24'd0, e.data});
          check("latency edge", mon_edges, e.due);
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN
          check("m_zero", {31'd0, m_zero}, {31'd0, e.zero});
`endif
        end
      end else if (sb.size() != 0 && sb[0].due <= mon_edges) begin
        check("missing m_valid", {31'd0, m_valid}, 32'd1);
        void'(sb.pop_front());
      end
      prev_data  = m_data;
      prev_valid = m_valid;
    end
  end

  // Watchdog: the stimulus is clock-driven, so this only guards against a
  // broken simulator setup.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for three cycles.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'hFF, 8'hFF);

    // Opcode sweep: a=CA, b=5F, op 0..7 back to back.
    for (int op = 0; op < 8; op++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(op), 8'hCA, 8'h5F);
    idle(LATENCY, 1'b1);

    // OR-accumulate after a clear beat.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h01, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h10, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h80, 8'hFF);

    // Clear overrides acc and op; the next acc beat sees ACC_INIT.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'hFF, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 8'hFF);
    idle(LATENCY, 1'b1);

    // Single NOR beat, then cke pattern 0,1,1 (with extra low cycles).
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'h0F, 8'h30);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Reset mid-stream with beats in flight: none may emerge.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'(i + 1), 8'h40);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    idle(LATENCY + 2, 1'b1);

    // Zero-result and near-zero XOR.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'hA5, 8'hA5);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'hA5, 8'hA4);
    idle(LATENCY, 1'b1);

    // Randomized traffic including cke gaps, clears, acc chains and resets.
    for (int i = 0; i < 400; i++) begin
      logic rst, ck, vld, clr, acc;
      rst = ($urandom_range(0, 59) == 0);
      ck  = ($urandom_range(0, 3) != 0);
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 9) == 0);
      acc = ($urandom_range(0, 1) == 1);
      drive(rst, ck, vld, clr, acc, 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom));
    end

    // Drain and confirm every expected beat came out.
    idle(LATENCY + 4, 1'b1);
    @(negedge clk);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_logic.md
Name: elixirchip_es1_spu_op_logic

Overview:
Parametrised multi-function bitwise logic unit for the ES1 SPU op library, replacing the single-function and/nor/xor style op blocks. The operation is selected per beat by an opcode. An optional accumulate path feeds the previous result back as operand 1, giving running reductions (e.g. OR-reduce across a vector stream). It has a LATENCY-deep pipeline with cke, clear and a valid sideband, and slots into SPU datapaths like any other spu_op block.

Parameters:
LATENCY, 1, pipeline depth in cycles; must be >=1 (elaboration error otherwise).
DATA_BITS, 8, operand/result width.
data_t, logic [DATA_BITS-1:0], data type.
CLEAR_DATA, 0, m_data value produced by a clear beat.
RESET_DATA, 0, value of m_data and of the accumulator after reset.
ACC_INIT, 0, accumulator value loaded by a clear beat.
IMMEDIATE_DATA1, 1'b0, synthesis hint that s_data1 is constant; no functional effect.
DEVICE, "RTL", target device.
SIMULATION, "false", simulation switch.
DEBUG, "false", debug switch.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
cke  in  1  clock enable; all state holds when 0
s_data0  in  DATA_BITS  operand a
s_data1  in  DATA_BITS  operand b; ignored when s_acc=1
s_op  in  3  opcode
s_acc  in  1  1: operand b = accumulator
s_clear  in  1  clear beat
s_valid  in  1  beat valid
m_data  out  DATA_BITS  result
m_valid  out  1  result valid

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Opcodes (a=s_data0, b=operand b):
  - 0 AND; 1 OR; 2 XOR; 3 NAND (~(a&b)); 4 NOR (~(a|b)); 5 XNOR; 6 ANDN (a&~b); 7 ORN (a|~b).
- Stage 1, evaluated only when cke=1:
  - Valid beat, s_clear=0: r = f(s_op, a, b). The accumulator loads r.
  - Valid beat, s_clear=1: r = CLEAR_DATA and the accumulator loads ACC_INIT. s_op and s_acc are ignored.
  - s_valid=0: the stage-1 data register and the accumulator hold. Stage-1 valid is 0.
- Stages 2..LATENCY: plain shift on cke. Data and valid move together, and data shifts even when valid is 0.
- Latency: a valid beat accepted at cke edge n appears on m_data/m_valid after LATENCY cke-enabled edges. With cke held low, outputs are frozen.
- Accumulator ordering: the accumulator is updated in stage 1, so back-to-back s_acc beats see the previous beat's result with zero bubble, regardless of LATENCY.
- Simultaneous events:
  - reset overrides cke and all inputs.
  - clear overrides acc and op.
- Reset (synchronous, while reset=1 at a clk edge): all data stages = RESET_DATA, accumulator = RESET_DATA, all valid stages = 0.
  - Reset in mid-stream discards every in-flight beat; m_valid=0 on the cycle after the edge.
- Width: purely bitwise, with no carry or overflow. Full DATA_BITS is produced for every opcode.

Optional Feature:
Macro ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN.
- Defined: adds output port m_zero (1 bit). It is 1 when the result is all-zero, is computed in stage 1 and is pipelined alongside m_data with the same latency.
  - m_zero is 0 at reset.
  - On a clear beat, m_zero = (CLEAR_DATA==0).
- Undefined: the port and its registers do not exist.

Test Plan:
- Opcode sweep, LATENCY=1, DATA_BITS=8, a=8'hCA, b=8'h5F, op 0..7 on consecutive cycles -> m_data 8'h4A, 8'hDF, 8'h95, 8'hB5, 8'h20, 8'h6A, 8'h80, 8'hEA one cycle later each, with m_valid=1.
- OR-accumulate: clear beat, then s_acc=1, op=1, a = 8'h01, 8'h10, 8'h80 back-to-back -> m_data CLEAR_DATA, 8'h01, 8'h11, 8'h91.
- LATENCY=3 with cke pattern 1,0,1,1 after a single NOR beat (a=8'h0F, b=8'h30) -> m_data=8'hC0 and m_valid=1 only after the 3rd cke-high edge. Outputs hold while cke=0.
- Clear overrides: s_clear=1, s_acc=1, op=2 -> m_data=CLEAR_DATA. The next acc beat uses ACC_INIT as b.
- Reset mid-stream, LATENCY=4, with 3 valid beats in flight: assert reset for 1 cycle -> m_valid=0, m_data=RESET_DATA, and none of the 3 beats emerge.
- ELIXIRCHIP_ES1_SPU_OP_LOGIC_ZERO_FLAG_EN defined, XOR a=b=8'hA5 -> m_data=8'h00 with m_zero=1 in the same cycle. a=8'hA5, b=8'hA4 -> m_zero=0.
